// File: rtl/score_pkg.sv
// Shared definitions for the score renderer: FSM states, geometry defaults
// and the 3x5 digit glyph masks.
package score_pkg;

  localparam int unsigned ROW_W_DEF       = 16;
  localparam int unsigned DIGIT_PITCH_DEF = 4;
  localparam int unsigned GLYPH_ROWS      = 5;
  localparam int unsigned GLYPH_COLS      = 3;
  localparam int unsigned GLYPH_BITS      = GLYPH_ROWS * GLYPH_COLS;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_CONV_H,
    S_CONV_T,
    S_DRAW0,
    S_DRAW1,
    S_DRAW2,
    S_DONE
  } state_e;

  // One glyph row, bit c is column c (column 0 is leftmost on the bitmap).
  localparam logic [2:0] R_ALL = 3'b111;
  localparam logic [2:0] R_LR  = 3'b101;
  localparam logic [2:0] R_L   = 3'b001;
  localparam logic [2:0] R_R   = 3'b100;

  // Mask bit r*3+c is glyph cell (row r, column c); rows listed bottom (4) to top (0).
  localparam logic [GLYPH_BITS-1:0] GLYPH_TABLE [10] = '{
    {R_ALL, R_LR,  R_LR,  R_LR,  R_ALL},  // 0
    {R_R,   R_R,   R_R,   R_R,   R_R  },  // 1
    {R_ALL, R_L,   R_ALL, R_R,   R_ALL},  // 2
    {R_ALL, R_R,   R_ALL, R_R,   R_ALL},  // 3
    {R_R,   R_R,   R_ALL, R_LR,  R_LR },  // 4
    {R_ALL, R_R,   R_ALL, R_L,   R_ALL},  // 5
    {R_ALL, R_LR,  R_ALL, R_L,   R_ALL},  // 6
    {R_R,   R_R,   R_R,   R_R,   R_ALL},  // 7
    {R_ALL, R_LR,  R_ALL, R_LR,  R_ALL},  // 8
    {R_ALL, R_R,   R_ALL, R_LR,  R_ALL}   // 9
  };

endpackage

// File: rtl/digit_glyph.sv
// Combinational lookup of the 3x5 glyph mask for one decimal digit.
module digit_glyph
  import score_pkg::*;
(
  input  logic [3:0]            digit_i,
  output logic [GLYPH_BITS-1:0] mask_o
);

  // Non-decimal codes render as blank.
  always_comb begin
    mask_o = '0;
    if (digit_i <= 4'd9) begin
      mask_o = GLYPH_TABLE[digit_i];
    end
  end

endmodule

// File: rtl/score_render_ctrl.sv
// Converts a binary score to three BCD digits by repeated subtraction and
// renders them as 3x5 glyphs into a row-major bitmap, one digit per cycle.
module score_render_ctrl
  import score_pkg::*;
#(
  parameter int unsigned BITMAP_W    = 768,
  parameter int unsigned ROW_W       = ROW_W_DEF,
  parameter int unsigned DIGIT_PITCH = DIGIT_PITCH_DEF
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic [9:0]          score_value,
  input  logic [9:0]          base_step,
  input  logic                blank_lz,
  output logic                busy,
  output logic                done,
  output logic [11:0]         digits_bcd,
  output logic [BITMAP_W-1:0] bitmap
);

  localparam int unsigned IDX_W = (BITMAP_W > 1) ? $clog2(BITMAP_W) : 1;

  state_e                state_q, state_d;
  logic [9:0]            value_q, value_d;
  logic [9:0]            base_q, base_d;
  logic                  blank_q, blank_d;
  logic [9:0]            rem_q, rem_d;
  logic [3:0]            hund_q, hund_d;
  logic [3:0]            tens_q, tens_d;
  logic [3:0]            units_q, units_d;
  logic [BITMAP_W-1:0]   bitmap_q, bitmap_d;
  logic                  busy_q, done_q;

  logic [3:0]            draw_digit_c;
  int unsigned           origin_c;
  logic                  draw_en_c;
  logic [GLYPH_BITS-1:0] mask_c;
  logic [BITMAP_W-1:0]   overlay_c;

  // Select the digit, origin and blanking decision for the current draw state.
  always_comb begin
    draw_digit_c = hund_q;
    origin_c     = 32'(base_q);
    draw_en_c    = 1'b0;
    case (state_q)
      S_DRAW0: begin
        draw_digit_c = hund_q;
        origin_c     = 32'(base_q);
        draw_en_c    = !(blank_q && (hund_q == 4'd0));
      end
      S_DRAW1: begin
        draw_digit_c = tens_q;
        origin_c     = 32'(base_q) + DIGIT_PITCH;
        draw_en_c    = !(blank_q && (hund_q == 4'd0) && (tens_q == 4'd0));
      end
      S_DRAW2: begin
        draw_digit_c = units_q;
        origin_c     = 32'(base_q) + 2 * DIGIT_PITCH;
        draw_en_c    = 1'b1;
      end
      default: ;
    endcase
  end

  digit_glyph u_glyph (
    .digit_i (draw_digit_c),
    .mask_o  (mask_c)
  );

  // Place the glyph cells on the bitmap; cells past the last bit are dropped.
  always_comb begin
    int unsigned idx;
    overlay_c = '0;
    idx       = 0;
    for (int unsigned r = 0; r < GLYPH_ROWS; r++) begin
      for (int unsigned c = 0; c < GLYPH_COLS; c++) begin
        idx = origin_c + r * ROW_W + c;
        if (draw_en_c && mask_c[4'(r * GLYPH_COLS + c)] && (idx < BITMAP_W)) begin
          overlay_c[IDX_W'(idx)] = 1'b1;
        end
      end
    end
  end

  // Next-state logic: capture, clear, BCD conversion, draw, done.
  always_comb begin
    state_d  = state_q;
    value_d  = value_q;
    base_d   = base_q;
    blank_d  = blank_q;
    rem_d    = rem_q;
    hund_d   = hund_q;
    tens_d   = tens_q;
    units_d  = units_q;
    bitmap_d = bitmap_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          value_d = (score_value > 10'd999) ? 10'd999 : score_value;
          base_d  = base_step;
          blank_d = blank_lz;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        bitmap_d = '0;
        hund_d   = 4'd0;
        tens_d   = 4'd0;
        units_d  = 4'd0;
        rem_d    = value_q;
        state_d  = S_CONV_H;
      end
      S_CONV_H: begin
        if (rem_q >= 10'd100) begin
          rem_d  = rem_q - 10'd100;
          hund_d = hund_q + 4'd1;
        end else begin
          state_d = S_CONV_T;
        end
      end
      S_CONV_T: begin
        if (rem_q >= 10'd10) begin
          rem_d  = rem_q - 10'd10;
          tens_d = tens_q + 4'd1;
        end else begin
          units_d = rem_q[3:0];
          state_d = S_DRAW0;
        end
      end
      S_DRAW0: begin
        bitmap_d = bitmap_q | overlay_c;
        state_d  = S_DRAW1;
      end
      S_DRAW1: begin
        bitmap_d = bitmap_q | overlay_c;
        state_d  = S_DRAW2;
      end
      S_DRAW2: begin
        bitmap_d = bitmap_q | overlay_c;
        state_d  = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; status outputs registered from next state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      value_q  <= '0;
      base_q   <= '0;
      blank_q  <= 1'b0;
      rem_q    <= '0;
      hund_q   <= '0;
      tens_q   <= '0;
      units_q  <= '0;
      bitmap_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      value_q  <= value_d;
      base_q   <= base_d;
      blank_q  <= blank_d;
      rem_q    <= rem_d;
      hund_q   <= hund_d;
      tens_q   <= tens_d;
      units_q  <= units_d;
      bitmap_q <= bitmap_d;
      busy_q   <= (state_d != S_IDLE);
      done_q   <= (state_d == S_DONE);
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign digits_bcd = {hund_q, tens_q, units_q};
  assign bitmap     = bitmap_q;

endmodule

// File: tb/tb_score_render_ctrl.sv
// Scoreboard bench for score_render_ctrl: the driver queues the expected
// render from an arithmetic/ASCII-art model, the monitor checks on done.
module tb_score_render_ctrl;

  localparam int BW = 768;

  logic          clk;
  logic          resetn;
  logic          start;
  logic [9:0]    score_value;
  logic [9:0]    base_step;
  logic          blank_lz;
  logic          busy;
  logic          done;
  logic [11:0]   digits_bcd;
  logic [BW-1:0] bitmap;

  typedef struct {
    logic [11:0]   dig;
    logic [BW-1:0] bmp;
    int            lat;
    int            acc;
    int            pop;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_mis = 0;
  bit   prev_done = 0;

  score_render_ctrl dut (
    .clk         (clk),
    .resetn      (resetn),
    .start       (start),
    .score_value (score_value),
    .base_step   (base_step),
    .blank_lz    (blank_lz),
    .busy        (busy),
    .done        (done),
    .digits_bcd  (digits_bcd),
    .bitmap      (bitmap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint expv);
    n_vec++;
    if (act !== expv) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  task automatic chk_bmp(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  // Glyph art, rows top to bottom, three characters per row.
  function automatic string glyph_art(input int d);
    case (d)
      0: return "####.##.##.####";
      1: return "..#..#..#..#..#";
      2: return "###..#####..###";
      3: return "###..####..####";
      4: return "#.##.####..#..#";
      5: return "####..###..####";
      6: return "####..####.####";
      7: return "###..#..#..#..#";
      8: return "####.#####.####";
      9: return "####.####..####";
      default: return "...............";
    endcase
  endfunction

  function automatic exp_t model(input int v_in, input int base, input bit blank, input int pop);
    exp_t  e;
    int    v, idx;
    int    d[3];
    bit    draw[3];
    string art;
    v    = (v_in > 999) ? 999 : v_in;
    d[0] = v / 100;
    d[1] = (v / 10) % 10;
    d[2] = v % 10;
    draw[0] = !(blank && d[0] == 0);
    draw[1] = !(blank && d[0] == 0 && d[1] == 0);
    draw[2] = 1'b1;
    e.bmp = '0;
    for (int k = 0; k < 3; k++) begin
      if (draw[k]) begin
        art = glyph_art(d[k]);
        for (int r = 0; r < 5; r++) begin
          for (int c = 0; c < 3; c++) begin
            if (art[r*3+c] == "#") begin
              idx = base + 4 * k + 16 * r + c;
              if (idx < BW) e.bmp[idx] = 1'b1;
            end
          end
        end
      end
    end
    e.dig = {4'(d[0]), 4'(d[1]), 4'(d[2])};
    e.lat = 7 + d[0] + d[1];
    e.acc = 0;
    e.pop = pop;
    return e;
  endfunction

  // Wait for idle, issue one request, queue its expected render.
  task automatic issue(input int v, input int base, input bit blank, input int pop, input bit poke);
    exp_t e;
    int   n;
    e = model(v, base, blank, pop);
    n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("idle_before_start", busy, 0);
    start       = 1'b1;
    score_value = 10'(v);
    base_step   = 10'(base);
    blank_lz    = blank;
    @(posedge clk);
    #1;
    e.acc = cyc;
    sb.push_back(e);
    @(negedge clk);
    start       = 1'b0;
    score_value = 10'($urandom);
    base_step   = 10'($urandom);
    blank_lz    = 1'($urandom);
    if (poke) begin
      @(negedge clk);
      start       = 1'b1;
      score_value = 10'd777;
      base_step   = 10'd3;
      chk("busy_during_poke", busy, 1);
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_poke", busy, 1);
    end
  endtask

  // Monitor: compare each done pulse against the oldest queued expectation.
  always @(posedge clk) begin
    #1;
    if (resetn) begin
      if (prev_done) chk("done_width", done, 0);
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          chk("latency", cyc - mon_e.acc + 1, mon_e.lat);
          chk("digits_bcd", digits_bcd, mon_e.dig);
          chk("busy_in_done", busy, 1);
          chk_bmp("bitmap", bitmap, mon_e.bmp);
          if (mon_e.pop >= 0) chk("popcount", $countones(bitmap), mon_e.pop);
        end
      end
      prev_done = done;
    end else begin
      prev_done = 1'b0;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    resetn      = 1'b0;
    start       = 1'b0;
    score_value = '0;
    base_step   = '0;
    blank_lz    = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_digits", digits_bcd, 0);
    chk_bmp("rst_bitmap", bitmap, '0);
    resetn = 1'b1;

    issue(0,    0,   1'b1, 12, 1'b0);
    issue(999,  0,   1'b0, 36, 1'b0);
    issue(1000, 50,  1'b0, -1, 1'b0);
    issue(1,    0,   1'b1, 5,  1'b0);
    issue(888,  760, 1'b0, 6,  1'b0);
    issue(42,   100, 1'b1, -1, 1'b1);
    issue(7,    20,  1'b0, -1, 1'b0);
    issue(305,  200, 1'b1, -1, 1'b0);

    // Abort a conversion mid-way through the tens phase.
    n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    start       = 1'b1;
    score_value = 10'd345;
    base_step   = 10'd16;
    blank_lz    = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_digits", digits_bcd, 0);
    chk_bmp("abort_bitmap", bitmap, '0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    issue(560, 300, 1'b1, -1, 1'b0);
    for (int i = 0; i < 30; i++) begin
      issue(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
            1'($urandom_range(0, 1)), -1, 1'($urandom_range(0, 3) == 0));
    end

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("pending_expectations", sb.size(), 0);
    chk("final_idle", busy, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
